// File: rtl/tx_resp_arbiter.sv
// rtl/tx_resp_arbiter.sv - two-source response arbiter feeding the UART TX async-FIFO write port
//
// Purpose:
//   Shares one FIFO write port between register-file read data (1 byte) and
//   ALU results (2 bytes, LSB first). Each source has a one-entry holding
//   register with a VLD/RDY handshake. A frame is always written whole; the
//   ALU HI byte directly follows the LO byte. FIFO_FULL stalls the frame, and
//   stalled cycles are counted in a saturating debug counter.
//
// Ports:
//   CLK        in   system clock, all logic on posedge
//   RST        in   synchronous active-low reset
//   RF_DATA    in   register-file read byte
//   RF_VLD     in   RF_DATA valid (accepted when RF_VLD && RF_RDY)
//   RF_RDY     out  RF holding register empty
//   ALU_DATA   in   ALU result (2*BYTE)
//   ALU_VLD    in   ALU_DATA valid (accepted when ALU_VLD && ALU_RDY)
//   ALU_RDY    out  ALU holding register empty
//   FIFO_FULL  in   FIFO full flag, write-domain view
//   TX_P_Data  out  byte presented to the FIFO (0 when idle)
//   TX_D_VLD   out  FIFO write enable
//   BUSY       out  FSM active or either holding register occupied
//   STALL_CNT  out  saturating count of cycles blocked by FIFO_FULL

module tx_resp_arbiter #(
  parameter int BYTE    = 8,
  parameter bit RR_MODE = 1'b1,
  parameter int STALL_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BYTE-1:0]      RF_DATA,
  input  logic                 RF_VLD,
  output logic                 RF_RDY,
  input  logic [2*BYTE-1:0]    ALU_DATA,
  input  logic                 ALU_VLD,
  output logic                 ALU_RDY,
  input  logic                 FIFO_FULL,
  output logic [BYTE-1:0]      TX_P_Data,
  output logic                 TX_D_VLD,
  output logic                 BUSY,
  output logic [STALL_W-1:0]   STALL_CNT
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_RF = 2'd1,
    SEND_LO = 2'd2,
    SEND_HI = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic                rf_v;
  logic [BYTE-1:0]     rf_q;
  logic                alu_v;
  logic [2*BYTE-1:0]   alu_q;
  logic                rr_last_alu;   // 1 = last grant went to ALU
  logic [STALL_W-1:0]  stall_q;

  logic                rf_acc;
  logic                alu_acc;
  logic                wr_ok;         // a SEND state may write this cycle
  logic                tie_alu;       // who wins when both sources are pending

  assign rf_acc  = RF_VLD && !rf_v;
  assign alu_acc = ALU_VLD && !alu_v;
  assign wr_ok   = (state != IDLE) && !FIFO_FULL;
  assign tie_alu = RR_MODE ? !rr_last_alu : 1'b1;

  // State register, plus the round-robin pointer which only moves on a grant.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      rr_last_alu <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == SEND_RF) rr_last_alu <= 1'b0;
      if (state == IDLE && state_nxt == SEND_LO) rr_last_alu <= 1'b1;
    end
  end

  // Next-state logic. Arbitration looks only at registered valids, so an
  // accept in an IDLE cycle is granted on the following cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rf_v && alu_v)  state_nxt = tie_alu ? SEND_LO : SEND_RF;
        else if (rf_v)      state_nxt = SEND_RF;
        else if (alu_v)     state_nxt = SEND_LO;
      end
      SEND_RF: if (!FIFO_FULL) state_nxt = IDLE;
      SEND_LO: if (!FIFO_FULL) state_nxt = SEND_HI;
      SEND_HI: if (!FIFO_FULL) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: the byte stays on TX_P_Data while stalled.
  always_comb begin
    TX_D_VLD  = wr_ok;
    TX_P_Data = '0;
    case (state)
      SEND_RF: TX_P_Data = rf_q;
      SEND_LO: TX_P_Data = alu_q[BYTE-1:0];
      SEND_HI: TX_P_Data = alu_q[2*BYTE-1:BYTE];
      default: TX_P_Data = '0;
    endcase
  end

  // Holding registers. Data is frozen while valid; valid drops on the edge
  // that writes the frame's last byte, so RDY rises one cycle later.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rf_v  <= 1'b0;
      rf_q  <= '0;
      alu_v <= 1'b0;
      alu_q <= '0;
    end else begin
      if (rf_acc) begin
        rf_v <= 1'b1;
        rf_q <= RF_DATA;
      end else if (state == SEND_RF && !FIFO_FULL) begin
        rf_v <= 1'b0;
      end

      if (alu_acc) begin
        alu_v <= 1'b1;
        alu_q <= ALU_DATA;
      end else if (state == SEND_HI && !FIFO_FULL) begin
        alu_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      stall_q <= '0;
    end else if (state != IDLE && FIFO_FULL && stall_q != {STALL_W{1'b1}}) begin
      stall_q <= stall_q + {{(STALL_W-1){1'b0}}, 1'b1};
    end
  end

  assign RF_RDY    = !rf_v;
  assign ALU_RDY   = !alu_v;
  assign BUSY      = (state != IDLE) || rf_v || alu_v;
  assign STALL_CNT = stall_q;

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// tb/tb_tx_resp_arbiter.sv - self-checking bench for tx_resp_arbiter with a frame-queue reference model

module tb_tx_resp_arbiter;

  localparam int BYTE    = 8;
  localparam bit RR_MODE = 1'b1;
  localparam int STALL_W = 8;
  localparam int STALL_MAX = (1 << STALL_W) - 1;

  logic              clk;
  logic              rst;
  logic [BYTE-1:0]   rf_data;
  logic              rf_vld;
  logic              rf_rdy;
  logic [2*BYTE-1:0] alu_data;
  logic              alu_vld;
  logic              alu_rdy;
  logic              fifo_full;
  logic [BYTE-1:0]   tx_data;
  logic              tx_vld;
  logic              busy;
  logic [STALL_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  tx_resp_arbiter #(.BYTE(BYTE), .RR_MODE(RR_MODE), .STALL_W(STALL_W)) dut (
    .CLK       (clk),
    .RST       (rst),
    .RF_DATA   (rf_data),
    .RF_VLD    (rf_vld),
    .RF_RDY    (rf_rdy),
    .ALU_DATA  (alu_data),
    .ALU_VLD   (alu_vld),
    .ALU_RDY   (alu_rdy),
    .FIFO_FULL (fifo_full),
    .TX_P_Data (tx_data),
    .TX_D_VLD  (tx_vld),
    .BUSY      (busy),
    .STALL_CNT (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending slots per source and the bytes still to be
  // written for the frame currently owned by the FIFO port.
  bit              m_valid = 1'b0;
  bit              m_rf_pend, m_alu_pend;
  logic [7:0]      m_rf_byte;
  logic [15:0]     m_alu_word;
  logic [7:0]      m_frame[$];
  bit              m_frame_alu;
  bit              m_last_alu;
  int              m_stall;

  always @(negedge clk) begin
    bit acc_rf, acc_alu, pick_alu;
    if (m_valid) begin
      check("tx_vld",   32'(tx_vld),    32'((m_frame.size() > 0) && !fifo_full));
      check("tx_data",  32'(tx_data),   (m_frame.size() > 0) ? 32'(m_frame[0]) : 32'd0);
      check("rf_rdy",   32'(rf_rdy),    32'(!m_rf_pend));
      check("alu_rdy",  32'(alu_rdy),   32'(!m_alu_pend));
      check("busy",     32'(busy),      32'((m_frame.size() > 0) || m_rf_pend || m_alu_pend));
      check("stall",    32'(stall_cnt), 32'(m_stall));
    end
    // Advance the model to what the coming posedge produces.
    if (!rst) begin
      m_valid    = 1'b1;
      m_rf_pend  = 1'b0;
      m_alu_pend = 1'b0;
      m_frame.delete();
      m_last_alu = 1'b1;
      m_stall    = 0;
    end else if (m_valid) begin
      acc_rf  = rf_vld && !m_rf_pend;
      acc_alu = alu_vld && !m_alu_pend;
      if (m_frame.size() > 0) begin
        if (fifo_full) begin
          if (m_stall < STALL_MAX) m_stall++;
        end else begin
          void'(m_frame.pop_front());
          if (m_frame.size() == 0) begin
            if (m_frame_alu) m_alu_pend = 1'b0;
            else             m_rf_pend  = 1'b0;
          end
        end
      end else if (m_rf_pend || m_alu_pend) begin
        if (m_rf_pend && m_alu_pend) pick_alu = RR_MODE ? !m_last_alu : 1'b1;
        else                         pick_alu = m_alu_pend;
        if (pick_alu) begin
          m_frame.push_back(m_alu_word[7:0]);
          m_frame.push_back(m_alu_word[15:8]);
        end else begin
          m_frame.push_back(m_rf_byte);
        end
        m_frame_alu = pick_alu;
        m_last_alu  = pick_alu;
      end
      if (acc_rf) begin
        m_rf_pend = 1'b1;
        m_rf_byte = rf_data;
      end
      if (acc_alu) begin
        m_alu_pend = 1'b1;
        m_alu_word = alu_data;
      end
    end
  end

  // Advance one clock; inputs change 1 unit after the edge, literal checks 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; rf_data = '0; rf_vld = 1'b0; alu_data = '0; alu_vld = 1'b0; fifo_full = 1'b0;
    do_reset();
    settle();
    check("reset_rf_rdy",  32'(rf_rdy),    32'd1);
    check("reset_alu_rdy", 32'(alu_rdy),   32'd1);
    check("reset_vld",     32'(tx_vld),    32'd0);
    check("reset_data",    32'(tx_data),   32'd0);
    check("reset_busy",    32'(busy),      32'd0);
    check("reset_stall",   32'(stall_cnt), 32'd0);

    // 1: single RF byte, written the cycle after accept.
    rf_vld = 1'b1; rf_data = 8'h5A;
    tick(); rf_vld = 1'b0; settle();
    check("t1_wait_vld", 32'(tx_vld), 32'd0);
    check("t1_rf_rdy",   32'(rf_rdy), 32'd0);
    tick(); settle();
    check("t1_vld",  32'(tx_vld),  32'd1);
    check("t1_data", 32'(tx_data), 32'h5A);
    tick(); settle();
    check("t1_done_vld", 32'(tx_vld), 32'd0);
    check("t1_rf_rdy2",  32'(rf_rdy), 32'd1);

    // 2: ALU pair LSB first.
    alu_vld = 1'b1; alu_data = 16'hBEEF;
    tick(); alu_vld = 1'b0;
    tick(); settle();
    check("t2_lo_vld", 32'(tx_vld), 32'd1);
    check("t2_lo",     32'(tx_data), 32'hEF);
    tick(); settle();
    check("t2_hi_vld", 32'(tx_vld), 32'd1);
    check("t2_hi",     32'(tx_data), 32'hBE);
    check("t2_busy_rdy", 32'(alu_rdy), 32'd0);
    tick(); settle();
    check("t2_alu_rdy", 32'(alu_rdy), 32'd1);

    // 3: tie after reset -> RF first; after a lone RF frame the next tie goes to ALU.
    do_reset();
    rf_vld = 1'b1; rf_data = 8'h11; alu_vld = 1'b1; alu_data = 16'h2233;
    tick(); rf_vld = 1'b0; alu_vld = 1'b0;
    tick(); settle();
    check("t3_first_rf", 32'(tx_data), 32'h11);
    tick(); tick(); settle();
    check("t3_lo", 32'(tx_data), 32'h33);
    tick(); settle();
    check("t3_hi", 32'(tx_data), 32'h22);
    rf_vld = 1'b1; rf_data = 8'h77;
    tick(); rf_vld = 1'b0;
    tick(); settle();
    check("t3_lone_rf", 32'(tx_data), 32'h77);
    tick();
    rf_vld = 1'b1; rf_data = 8'h44; alu_vld = 1'b1; alu_data = 16'h6655;
    tick(); rf_vld = 1'b0; alu_vld = 1'b0;
    tick(); settle();
    check("t3_tie2_alu_lo", 32'(tx_data), 32'h55);
    tick(); settle();
    check("t3_tie2_alu_hi", 32'(tx_data), 32'h66);
    tick(); tick(); settle();
    check("t3_tie2_rf", 32'(tx_data), 32'h44);
    tick();

    // 4: stall 5 cycles in SEND_LO with RF pending.
    do_reset();
    alu_vld = 1'b1; alu_data = 16'hBEEF;
    tick(); alu_vld = 1'b0; rf_vld = 1'b1; rf_data = 8'hC3; fifo_full = 1'b1;
    tick(); rf_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("t4_stall_vld",  32'(tx_vld),  32'd0);
      check("t4_stall_data", 32'(tx_data), 32'hEF);
      tick();
    end
    fifo_full = 1'b0; settle();
    check("t4_stall_cnt", 32'(stall_cnt), 32'd5);
    check("t4_lo",        32'(tx_data),   32'hEF);
    tick(); settle();
    check("t4_hi", 32'(tx_data), 32'hBE);
    tick(); tick(); settle();
    check("t4_rf",     32'(tx_data), 32'hC3);
    check("t4_rf_vld", 32'(tx_vld),  32'd1);
    tick();

    // 5: reset between LO and HI abandons the frame.
    alu_vld = 1'b1; alu_data = 16'hA55A;
    tick(); alu_vld = 1'b0;
    tick(); settle();
    check("t5_lo", 32'(tx_data), 32'h5A);
    rst = 1'b0;
    tick(); rst = 1'b1; settle();
    check("t5_rf_rdy",  32'(rf_rdy),    32'd1);
    check("t5_alu_rdy", 32'(alu_rdy),   32'd1);
    check("t5_stall",   32'(stall_cnt), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("t5_no_hi", 32'(tx_vld), 32'd0);
      tick(); settle();
    end

    // 6: long stall saturates the counter.
    rf_vld = 1'b1; rf_data = 8'h99; fifo_full = 1'b1;
    tick(); rf_vld = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    settle();
    check("t6_sat", 32'(stall_cnt), 32'hFF);
    fifo_full = 1'b0;
    tick(); tick();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rf_vld    = ($urandom_range(0, 99) < 40);
      alu_vld   = ($urandom_range(0, 99) < 40);
      rf_data   = 8'($urandom);
      alu_data  = 16'($urandom);
      fifo_full = ($urandom_range(0, 99) < 30);
      rst       = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst = 1'b1; rf_vld = 1'b0; alu_vld = 1'b0; fifo_full = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
